// File: rtl/axi_lite_rd_arbiter.sv
// Two-port AXI-lite read arbiter (IFU fetch / LSU load), one read in flight.
// Define ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module axi_lite_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  ifu_arvalid_i,
  output logic                  ifu_arready_o,
  input  logic [ADDR_WIDTH-1:0] ifu_araddr_i,
  output logic                  ifu_rvalid_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  output logic [1:0]            ifu_rresp_o,
  input  logic                  ifu_rready_i,
  input  logic                  lsu_arvalid_i,
  output logic                  lsu_arready_o,
  input  logic [ADDR_WIDTH-1:0] lsu_araddr_i,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic [1:0]            lsu_rresp_o,
  input  logic                  lsu_rready_i,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  output logic [ADDR_WIDTH-1:0] m_araddr_o,
  input  logic                  m_rvalid_i,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic [1:0]            m_rresp_i,
  output logic                  m_rready_o
);

  typedef enum logic [2:0] {
    IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  arvalid_d;
  logic                  drop_q, drop_d;
  logic                  ifu_req, lsu_req, pick_lsu;
  logic                  r_hs;

  // A flushed fetch must not start a new read.
  assign ifu_req = ifu_arvalid_i & ~flush_i;
  assign lsu_req = lsu_arvalid_i;

`ifdef ARB_RR_EN
  logic last_lsu_q, last_lsu_d;
  assign pick_lsu = lsu_req & (~ifu_req | ~last_lsu_q);
`else
  assign pick_lsu = lsu_req;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = m_araddr_o;
    arvalid_d     = m_arvalid_o;
    drop_d        = drop_q;
    r_hs          = 1'b0;
    ifu_arready_o = 1'b0;
    lsu_arready_o = 1'b0;
    ifu_rvalid_o  = 1'b0;
    ifu_rdata_o   = '0;
    ifu_rresp_o   = '0;
    lsu_rvalid_o  = 1'b0;
    lsu_rdata_o   = '0;
    lsu_rresp_o   = '0;
    m_rready_o    = 1'b0;
`ifdef ARB_RR_EN
    last_lsu_d    = last_lsu_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_lsu) begin
          addr_d    = lsu_araddr_i;
          arvalid_d = 1'b1;
          state_d   = LSU_AR;
`ifdef ARB_RR_EN
          last_lsu_d = 1'b1;
`endif
        end else if (ifu_req) begin
          addr_d    = ifu_araddr_i;
          arvalid_d = 1'b1;
          state_d   = IFU_AR;
`ifdef ARB_RR_EN
          last_lsu_d = 1'b0;
`endif
        end
      end
      IFU_AR: begin
        ifu_arready_o = m_arready_i;
        if (flush_i) drop_d = 1'b1;
        if (m_arready_i) begin
          arvalid_d = 1'b0;
          state_d   = IFU_R;
        end
      end
      IFU_R: begin
        // A stale beat is drained here without reaching the IFU.
        m_rready_o   = drop_q | ifu_rready_i;
        ifu_rvalid_o = m_rvalid_i & ~drop_q;
        ifu_rdata_o  = m_rdata_i;
        ifu_rresp_o  = m_rresp_i;
        r_hs         = m_rvalid_i & m_rready_o;
        if (r_hs) begin
          drop_d  = 1'b0;
          state_d = IDLE;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      LSU_AR: begin
        lsu_arready_o = m_arready_i;
        if (m_arready_i) begin
          arvalid_d = 1'b0;
          state_d   = LSU_R;
        end
      end
      LSU_R: begin
        m_rready_o   = lsu_rready_i;
        lsu_rvalid_o = m_rvalid_i;
        lsu_rdata_o  = m_rdata_i;
        lsu_rresp_o  = m_rresp_i;
        r_hs         = m_rvalid_i & lsu_rready_i;
        if (r_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      m_arvalid_o <= 1'b0;
      m_araddr_o  <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_arvalid_o <= arvalid_d;
      m_araddr_o  <= addr_d;
      drop_q      <= drop_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_lsu_q <= 1'b1;
    else         last_lsu_q <= last_lsu_d;
  end
`endif

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Self-checking bench for axi_lite_rd_arbiter: cycle vector table,
// reset corner case, and a scoreboarded contention run.
module tb_axi_lite_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [1:0]  m_rresp;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  axi_lite_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(ifu_arready),
    .ifu_araddr_i(ifu_araddr), .ifu_rvalid_o(ifu_rvalid),
    .ifu_rdata_o(ifu_rdata), .ifu_rresp_o(ifu_rresp),
    .ifu_rready_i(ifu_rready),
    .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(lsu_arready),
    .lsu_araddr_i(lsu_araddr), .lsu_rvalid_o(lsu_rvalid),
    .lsu_rdata_o(lsu_rdata), .lsu_rresp_o(lsu_rresp),
    .lsu_rready_i(lsu_rready),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
    .m_araddr_o(m_araddr), .m_rvalid_i(m_rvalid),
    .m_rdata_i(m_rdata), .m_rresp_i(m_rresp),
    .m_rready_o(m_rready)
  );

  typedef struct {
    logic        fl, iv, lv, ard, rv, irr, lrr;
    logic [31:0] ia, la, rd;
    logic [1:0]  rr;
    logic        mav, iar, lar, irv, lrv, mrr;
    logic [31:0] maa, erd;
    logic [1:0]  err;
  } vec_t;

  vec_t tv[$];

  localparam logic [31:0] A0  = 32'h8000_0000;
  localparam logic [31:0] A4  = 32'h8000_0004;
  localparam logic [31:0] A8  = 32'h8000_0008;
  localparam logic [31:0] AC  = 32'h8000_000C;
  localparam logic [31:0] A10 = 32'h8000_0010;
  localparam logic [31:0] L1  = 32'h8000_1000;
  localparam logic [31:0] L2  = 32'h8000_2000;
  localparam logic [31:0] L3  = 32'h8000_3000;
  localparam logic [31:0] L5  = 32'h8000_5000;
  localparam logic [31:0] L6  = 32'h8000_6000;
  localparam logic [31:0] K   = 32'h5A5A_0000;

  function automatic vec_t mk(
    input int fl, input int iv, input logic [31:0] ia,
    input int lv, input logic [31:0] la, input int ard,
    input int rv, input logic [31:0] rd, input int rr,
    input int irr, input int lrr,
    input int mav, input logic [31:0] maa, input int iar,
    input int lar, input int irv, input int lrv, input int mrr,
    input logic [31:0] erd, input int err);
    vec_t v;
    v.fl = 1'(fl);   v.iv = 1'(iv);   v.ia = ia;
    v.lv = 1'(lv);   v.la = la;       v.ard = 1'(ard);
    v.rv = 1'(rv);   v.rd = rd;       v.rr = 2'(rr);
    v.irr = 1'(irr); v.lrr = 1'(lrr);
    v.mav = 1'(mav); v.maa = maa;     v.iar = 1'(iar);
    v.lar = 1'(lar); v.irv = 1'(irv); v.lrv = 1'(lrv);
    v.mrr = 1'(mrr); v.erd = erd;     v.err = 2'(err);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; ifu_arvalid = 0; ifu_araddr = '0; ifu_rready = 0;
    lsu_arvalid = 0; lsu_araddr = '0; lsu_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic logic [71:0] outs();
    logic [31:0] d;
    logic [1:0]  r;
    d = ifu_rvalid ? ifu_rdata : (lsu_rvalid ? lsu_rdata : 32'h0);
    r = ifu_rvalid ? ifu_rresp : (lsu_rvalid ? lsu_rresp : 2'h0);
    return {m_arvalid, m_araddr, ifu_arready, lsu_arready,
            ifu_rvalid, lsu_rvalid, m_rready, d, r};
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ar_q[$];
    logic [32:0] r_q[$];
    logic        pend;
    logic [31:0] pdata;

    rst_n = 0;
    idle_inputs();
    ifu_rready = 1;
    lsu_rready = 1;
    #1;
    chk("reset_outs", 72'(outs()), 72'h0);
    apply_reset();

    // single IFU read
    tv.push_back(mk(0,1,A0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,A0,0,0,1,0,0,0,0,0, 1,A0,1,0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 0,A0,0,0,0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h413,0,1,0,
                    0,A0,0,0,1,0,1,32'h413,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,A0,0,0,0,0,0,0,0));
    // LSU with AR then R backpressure, SLVERR forwarded
    tv.push_back(mk(0,0,0,1,L2,0,0,0,0,0,0, 0,A0,0,0,0,0,0,0,0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(0,0,0,1,L2,0,0,0,0,0,0, 1,L2,0,0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,L2,1,0,0,0,0,0, 1,L2,0,1,0,0,0,0,0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0,0,0,0,0,0,1,32'hDEADBEEF,2,0,0,
                      0,L2,0,0,0,1,0,32'hDEADBEEF,2));
    tv.push_back(mk(0,0,0,0,0,0,1,32'hDEADBEEF,2,0,1,
                    0,L2,0,0,0,1,1,32'hDEADBEEF,2));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,L2,0,0,0,0,0,0,0));
    // flush in IFU_R drops the beat, then LSU proceeds
    tv.push_back(mk(0,1,A8,0,0,0,0,0,0,0,0, 0,L2,0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,A8,0,0,1,0,0,0,0,0, 1,A8,1,0,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,1,0, 0,A8,0,0,0,0,1,0,0));
    tv.push_back(mk(0,0,0,1,L3,0,1,32'h11111111,0,0,0,
                    0,A8,0,0,0,0,1,0,0));
    tv.push_back(mk(0,0,0,1,L3,0,0,0,0,0,0, 0,A8,0,0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,L3,1,0,0,0,0,0, 1,L3,0,1,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,1,32'h22222222,0,0,1,
                    0,L3,0,0,0,1,1,32'h22222222,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,L3,0,0,0,0,0,0,0));
    // flush coincident with R handshake still delivers
    tv.push_back(mk(0,1,AC,0,0,0,0,0,0,0,0, 0,L3,0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,AC,0,0,1,0,0,0,0,0, 1,AC,1,0,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,1,32'h33333333,1,1,0,
                    0,AC,0,0,1,0,1,32'h33333333,1));
    // no IFU grant under flush; flush in IFU_AR keeps AR, drops beat
    tv.push_back(mk(1,1,A10,0,0,0,0,0,0,0,0, 0,AC,0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,A10,0,0,0,0,0,0,0,0, 0,AC,0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,A10,0,0,0,0,0,0,0,0, 1,A10,0,0,0,0,0,0,0));
    tv.push_back(mk(0,1,A10,0,0,1,0,0,0,0,0, 1,A10,1,0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h44444444,0,0,0,
                    0,A10,0,0,0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,A10,0,0,0,0,0,0,0));

    foreach (tv[i]) begin
      @(negedge clk);
      flush = tv[i].fl; ifu_arvalid = tv[i].iv; ifu_araddr = tv[i].ia;
      lsu_arvalid = tv[i].lv; lsu_araddr = tv[i].la;
      m_arready = tv[i].ard; m_rvalid = tv[i].rv;
      m_rdata = tv[i].rd; m_rresp = tv[i].rr;
      ifu_rready = tv[i].irr; lsu_rready = tv[i].lrr;
      #1;
      chk($sformatf("vec%0d", i), 72'(outs()),
          {tv[i].mav, tv[i].maa, tv[i].iar, tv[i].lar, tv[i].irv,
           tv[i].lrv, tv[i].mrr, tv[i].erd, tv[i].err});
    end

    // asynchronous reset while in LSU_AR
    @(negedge clk);
    idle_inputs();
    lsu_arvalid = 1; lsu_araddr = L5;
    @(negedge clk);
    #1;
    chk("rst_pre", {m_arvalid, m_araddr}, {1'b1, L5});
    #2 rst_n = 0;
    #1;
    chk("rst_async", {m_arvalid, m_araddr, lsu_arready}, 34'h0);
    @(negedge clk);
    rst_n = 1;
    lsu_araddr = L6;
    #1;
    chk("rst_idle", {m_arvalid, lsu_arready}, 2'b00);
    @(negedge clk);
    #1;
    chk("rst_regrant", {m_arvalid, m_araddr}, {1'b1, L6});
    apply_reset();

    // contention with a scoreboard and a responding slave
`ifdef ARB_RR_EN
    ar_q = '{A4, L1};
    r_q  = '{{1'b0, A4 ^ K}, {1'b1, L1 ^ K}};
`else
    ar_q = '{L1, A4};
    r_q  = '{{1'b1, L1 ^ K}, {1'b0, A4 ^ K}};
`endif
    pend = 0;
    pdata = '0;
    @(negedge clk);
    ifu_arvalid = 1; ifu_araddr = A4;
    lsu_arvalid = 1; lsu_araddr = L1;
    ifu_rready = 1; lsu_rready = 1; m_arready = 1;
    for (int c = 0; c < 40 && (ar_q.size() > 0 || r_q.size() > 0); c++) begin
      if (c > 0) @(negedge clk);
      m_rvalid = pend;
      m_rdata  = pdata;
      #1;
      if (m_arvalid && m_arready) begin
        chk("sb_one_out", 1'(pend), 1'b0);
        if (ar_q.size() == 0) chk("sb_extra_ar", m_araddr, 32'hx);
        else chk("sb_ar", m_araddr, ar_q.pop_front());
        pend = 1;
        pdata = m_araddr ^ K;
      end
      if (ifu_arready) ifu_arvalid = 0;
      if (lsu_arready) lsu_arvalid = 0;
      if ((ifu_rvalid && ifu_rready) || (lsu_rvalid && lsu_rready)) begin
        if (r_q.size() == 0) chk("sb_extra_r", 33'h0, 33'hx);
        else if (ifu_rvalid) chk("sb_r", {1'b0, ifu_rdata}, r_q.pop_front());
        else chk("sb_r", {1'b1, lsu_rdata}, r_q.pop_front());
        pend = 0;
      end
    end
    chk("sb_drain", 64'({ar_q.size(), r_q.size()}), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/axi_lite_rd_arbiter.md
Name: axi_lite_rd_arbiter

Overview:
- Shares one AXI-lite read channel (AR/R) between two requesters: the IFU instruction fetch port and the LSU load port.
- Sits between ifu_axi_lite / LSU and the single AXI-lite master toward memory.
- Allows exactly one outstanding read at a time. Registers the winning address, locks the grant until the R beat completes, and drops IFU responses that a pipeline flush has made stale.

Parameters:
- ADDR_WIDTH, 32, AR address width.
- DATA_WIDTH, 32, R data width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; discards the in-flight IFU read
- ifu_arvalid_i  in  1  IFU read request
- ifu_arready_o  out  1  IFU address accepted
- ifu_araddr_i  in  ADDR_WIDTH  IFU fetch address
- ifu_rvalid_o  out  1  IFU read data valid
- ifu_rdata_o  out  DATA_WIDTH  IFU read data
- ifu_rresp_o  out  2  IFU read response
- ifu_rready_i  in  1  IFU ready for data
- lsu_arvalid_i  in  1  LSU read request
- lsu_arready_o  out  1  LSU address accepted
- lsu_araddr_i  in  ADDR_WIDTH  LSU load address
- lsu_rvalid_o  out  1  LSU read data valid
- lsu_rdata_o  out  DATA_WIDTH  LSU read data
- lsu_rresp_o  out  2  LSU read response
- lsu_rready_i  in  1  LSU ready for data
- m_arvalid_o  out  1  master AR valid (registered)
- m_arready_i  in  1  master AR ready
- m_araddr_o  out  ADDR_WIDTH  master AR address (registered)
- m_rvalid_i  in  1  master R valid
- m_rdata_i  in  DATA_WIDTH  master R data
- m_rresp_i  in  2  master R response
- m_rready_o  out  1  master R ready

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - m_arvalid_o = 0; m_araddr_o = 0.
  - drop flag = 0; last_grant = LSU.
  - All *_valid_o, *_ready_o = 0.
- States: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R.
- IDLE:
  - Grants when a requester has arvalid_i = 1. Fixed priority: LSU beats IFU.
  - No IFU grant in any cycle with flush_i = 1.
  - On grant: m_araddr_o <= granted araddr_i, m_arvalid_o <= 1, go to X_AR.
  - Request in cycle N appears on m_arvalid_o in cycle N+1.
- X_AR:
  - m_arvalid_o held at 1 with a stable address until m_arready_i.
  - x_arready_o = m_arready_i, combinational, only in this state.
  - On handshake: m_arvalid_o <= 0, go to X_R.
  - Requester must hold arvalid_i/araddr_i until its arready_o.
- X_R:
  - x_rvalid_o = m_rvalid_i; x_rdata_o/x_rresp_o pass through combinationally.
  - m_rready_o = x_rready_i.
  - On R handshake: go to IDLE. Earliest re-grant is the following cycle, so minimum 3 cycles per read.
- Flush:
  - flush_i = 1 in IFU_AR or IFU_R sets drop.
  - The AR is never withdrawn: m_arvalid_o stays 1 until accepted (AXI rule).
  - While drop = 1 in IFU_R: ifu_rvalid_o = 0, m_rready_o = 1. The beat is consumed silently.
  - drop clears on that R handshake.
  - Flush in LSU_* states: no effect.
- Simultaneous events:
  - Flush and IFU R handshake in the same cycle: the beat is still delivered (ifu_rvalid_o follows m_rvalid_i), drop is not set, and the state returns to IDLE.
  - Both requests in the same cycle as an R handshake: grant occurs in the next IDLE cycle.
- Idle outputs: outputs to the non-granted requester are always 0. rdata/rresp outputs are don't-care when the matching rvalid_o = 0.
- Error responses: rresp is forwarded unmodified. The arbiter takes no action on SLVERR/DECERR.
- Reset mid-transaction: all state returns to reset values immediately. The downstream slave is reset on the same rst_ni.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration.
  - last_grant is updated on every grant.
  - When both request in IDLE, the requester not in last_grant wins.
  - After reset (last_grant = LSU), IFU wins first.
- Undefined: fixed LSU priority as above; last_grant register absent.

Test Plan:
- Single IFU read:
  - Stimulus: ifu_arvalid_i = 1, addr 0x8000_0000; m_arready_i = 1 at cycle 1; m_rvalid_i at cycle 3 with data 0x0000_0413.
  - Required: m_arvalid_o = 1 at cycle 1 with addr 0x8000_0000; ifu_arready_o pulses at cycle 1; ifu_rvalid_o/ifu_rdata_o = 0x0000_0413 at cycle 3; IDLE at cycle 4.
- Contention:
  - Stimulus: IFU 0x8000_0004 and LSU 0x8000_1000 requested in the same cycle.
  - Required: m_araddr_o = 0x8000_1000 first; IFU AR is issued only after the LSU R handshake.
  - With ARB_RR_EN after reset: IFU 0x8000_0004 first, then LSU.
- AR backpressure:
  - Stimulus: m_arready_i low for 4 cycles.
  - Required: m_arvalid_o = 1 and m_araddr_o stable throughout; requester arready_o = 0 until the handshake.
- Flush during IFU_R:
  - Stimulus: flush_i pulses one cycle before m_rvalid_i.
  - Required: m_rready_o = 1, ifu_rvalid_o stays 0, beat consumed; a following LSU request is granted normally.
- R backpressure:
  - Stimulus: lsu_rready_i = 0 for 3 cycles while m_rvalid_i = 1, rresp = 2'b10.
  - Required: m_rready_o = 0 for those cycles; lsu_rresp_o = 2'b10 on the handshake.
- Reset mid-transaction:
  - Stimulus: rst_ni low asynchronously while in LSU_AR.
  - Required: m_arvalid_o = 0 immediately, state IDLE after release.
